// File: rtl/tmds_pkg.sv
// Shared TMDS definitions: control tokens, symbol width and
// the receive alignment FSM states.
package tmds_pkg;

  localparam int SYM_W = 10;

  localparam logic [SYM_W-1:0] TOK_CD00 = 10'b1101010100;
  localparam logic [SYM_W-1:0] TOK_CD01 = 10'b0010101011;
  localparam logic [SYM_W-1:0] TOK_CD10 = 10'b0101010100;
  localparam logic [SYM_W-1:0] TOK_CD11 = 10'b1010101011;

  typedef enum logic {
    SEARCH,
    LOCKED
  } align_state_e;

  typedef struct packed {
    logic       is_token;
    logic [1:0] cd;
    logic [7:0] vd;
  } sym_dec_t;

endpackage

// File: rtl/tmds_decoder_channel_if.sv
// Symbol input and decoded output bundle of one TMDS
// receive channel.
interface tmds_decoder_channel_if;
  import tmds_pkg::*;

  logic [SYM_W-1:0] tmds_in;
  logic [7:0]       vd;
  logic [1:0]       cd;
  logic             vde;
  logic             locked;
  logic [3:0]       bit_offset;
  logic             slip;

  modport master (
    output tmds_in,
    input  vd,
    input  cd,
    input  vde,
    input  locked,
    input  bit_offset,
    input  slip
  );

  modport slave (
    input  tmds_in,
    output vd,
    output cd,
    output vde,
    output locked,
    output bit_offset,
    output slip
  );

endinterface

// File: rtl/tmds_symbol_decode.sv
// Combinational TMDS symbol decode: control-token match
// plus 8-bit video data recovery.
module tmds_symbol_decode
  import tmds_pkg::*;
(
  input  logic [SYM_W-1:0] sym,
  output sym_dec_t         dec
);

  logic [7:0] d;

  always_comb begin
    dec = '0;
    d   = sym[7:0] ^ {8{sym[9]}};
    dec.vd[0] = d[0];
    for (int i = 1; i < 8; i++) begin
      dec.vd[i] = sym[8] ? (d[i] ^ d[i-1])
                         : ~(d[i] ^ d[i-1]);
    end
    unique case (1'b1)
      (sym == TOK_CD00): begin
        dec.is_token = 1'b1;
        dec.cd       = 2'b00;
      end
      (sym == TOK_CD01): begin
        dec.is_token = 1'b1;
        dec.cd       = 2'b01;
      end
      (sym == TOK_CD10): begin
        dec.is_token = 1'b1;
        dec.cd       = 2'b10;
      end
      (sym == TOK_CD11): begin
        dec.is_token = 1'b1;
        dec.cd       = 2'b11;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/tmds_decoder_channel.sv
// One TMDS receive channel: bit-slip word alignment on control
// tokens, then symbol decode into video data or control codes.
module tmds_decoder_channel
  import tmds_pkg::*;
#(
  parameter int lock_tokens    = 64,
  parameter int search_timeout = 2048,
  parameter int min_ctrl_run   = 8,
  parameter int max_gap        = 4096
) (
  input logic                  clk_pixel,
  input logic                  reset,
  tmds_decoder_channel_if.slave bus
);

  localparam int RUN_W = $clog2(lock_tokens + 1);
  localparam int TMO_W = $clog2(search_timeout + 1);
  localparam int GAP_W = $clog2(max_gap + 1);

  localparam logic [RUN_W-1:0] RUN_LOCK = RUN_W'(lock_tokens);
  localparam logic [RUN_W-1:0] RUN_CTRL = RUN_W'(min_ctrl_run);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(search_timeout - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(max_gap - 1);

  align_state_e     state_q, state_d;
  logic [RUN_W-1:0] run_q, run_d, run_inc;
  logic [TMO_W-1:0] tmo_q, tmo_d, tmo_inc;
  logic [GAP_W-1:0] gap_q, gap_d, gap_inc;
  logic [1:0]       flush_q, flush_d;
  logic [3:0]       off_q, off_d;
  logic             slip_q, slip_d;

  logic [SYM_W-1:0]   prev_q, sym_q, sym_sel;
  logic [2*SYM_W-1:0] window;
  sym_dec_t           dec;
  logic               tok;

  logic [7:0] vd_q;
  logic [1:0] cd_q;
  logic       vde_q;
  logic       locked;

  assign window  = {bus.tmds_in, prev_q};
  assign sym_sel = SYM_W'(window >> off_q);
  assign locked  = (state_q == LOCKED);

  always_ff @(posedge clk_pixel or posedge reset) begin
    if (reset) begin
      prev_q <= '0;
      sym_q  <= '0;
    end else begin
      prev_q <= bus.tmds_in;
      sym_q  <= sym_sel;
    end
  end

  tmds_symbol_decode u_dec (
    .sym (sym_q),
    .dec (dec)
  );

  // Symbols straddling a slip are stale, so they never count as tokens.
  assign tok = dec.is_token && (flush_q == 2'd0);

  assign run_inc = (run_q == RUN_LOCK) ? run_q : run_q + 1'b1;
  assign tmo_inc = (tmo_q == TMO_LAST) ? tmo_q : tmo_q + 1'b1;
  assign gap_inc = (gap_q == GAP_LAST) ? gap_q : gap_q + 1'b1;

  always_comb begin
    state_d = state_q;
    run_d   = run_q;
    tmo_d   = tmo_q;
    gap_d   = gap_q;
    flush_d = flush_q;
    off_d   = off_q;
    slip_d  = 1'b0;
    unique case (state_q)
      SEARCH: begin
        if (flush_q != 2'd0) flush_d = flush_q - 2'd1;
        run_d = tok ? run_inc : '0;
        tmo_d = tmo_inc;
        if (tok && run_inc == RUN_LOCK) begin
          state_d = LOCKED;
          run_d   = '0;
          tmo_d   = '0;
          gap_d   = '0;
        end else if (tmo_q == TMO_LAST) begin
          slip_d  = 1'b1;
          off_d   = (off_q == 4'd9) ? 4'd0 : off_q + 4'd1;
          run_d   = '0;
          tmo_d   = '0;
          flush_d = 2'd2;
        end
      end
      LOCKED: begin
        run_d = tok ? run_inc : '0;
        gap_d = gap_inc;
        if (tok && run_q != RUN_CTRL && run_inc == RUN_CTRL) begin
          gap_d = '0;
        end else if (gap_q == GAP_LAST) begin
          state_d = SEARCH;
          run_d   = '0;
          tmo_d   = '0;
          gap_d   = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk_pixel or posedge reset) begin
    if (reset) begin
      state_q <= SEARCH;
      run_q   <= '0;
      tmo_q   <= '0;
      gap_q   <= '0;
      flush_q <= '0;
      off_q   <= '0;
      slip_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      run_q   <= run_d;
      tmo_q   <= tmo_d;
      gap_q   <= gap_d;
      flush_q <= flush_d;
      off_q   <= off_d;
      slip_q  <= slip_d;
    end
  end

  always_ff @(posedge clk_pixel or posedge reset) begin
    if (reset) begin
      vd_q  <= '0;
      cd_q  <= '0;
      vde_q <= 1'b0;
    end else begin
      vde_q <= locked && !dec.is_token;
      vd_q  <= (locked && !dec.is_token) ? dec.vd : 8'h00;
      cd_q  <= (locked && dec.is_token) ? dec.cd : 2'b00;
    end
  end

  assign bus.vd         = vd_q;
  assign bus.cd         = cd_q;
  assign bus.vde        = vde_q;
  assign bus.locked     = locked;
  assign bus.bit_offset = off_q;
  assign bus.slip       = slip_q;

endmodule
